// File: rtl/input_conditioner.sv
// Front-end conditioner for the microwave controller: synchronises and debounces
// the 10-key pad and the start/stop/clear/door switches.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_raw,
  input  logic       startn_raw,
  input  logic       stopn_raw,
  input  logic       clearn_raw,
  input  logic       door_raw,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       door_closed,
  output logic       key_error
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Button vector order: {door, clearn, stopn, startn}; idle is all released, door open.
  localparam logic [3:0]       BTN_IDLE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    RELEASE = 2'd2
  } key_state_e;

  logic [9:0]       key_meta_q;
  logic [9:0]       key_s_q;
  logic [3:0]       btn_meta_q;
  logic [3:0]       btn_s_q;
  logic [3:0]       btn_raw;

  logic [3:0]       btn_q;
  logic [3:0]       btn_d;
  logic [CNT_W-1:0] btn_cnt_q [4];
  logic [CNT_W-1:0] btn_cnt_d [4];

  key_state_e       state_q;
  logic [9:0]       code_q;
  logic [CNT_W-1:0] kcnt_q;
  logic [9:0]       keypad_q;
  logic             key_error_q;

  assign btn_raw = {door_raw, clearn_raw, stopn_raw, startn_raw};

  // Stage 1-2: two-flop synchronisers for every raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= '0;
      key_s_q    <= '0;
      btn_meta_q <= BTN_IDLE;
      btn_s_q    <= BTN_IDLE;
    end else begin
      key_meta_q <= key_raw;
      key_s_q    <= key_meta_q;
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Button debounce: a change is accepted only after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    btn_d = btn_q;
    for (int i = 0; i < 4; i++) begin
      btn_cnt_d[i] = '0;
      if (btn_s_q[i] != btn_q[i]) begin
        if (btn_cnt_q[i] == DB_LAST) begin
          btn_d[i] = btn_s_q[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= BTN_IDLE;
      for (int i = 0; i < 4; i++) begin
        btn_cnt_q[i] <= '0;
      end
    end else begin
      btn_q <= btn_d;
      for (int i = 0; i < 4; i++) begin
        btn_cnt_q[i] <= btn_cnt_d[i];
      end
    end
  end

  // Key FSM: qualify a single held digit, pulse once, then wait for a clean release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      kcnt_q      <= '0;
      keypad_q    <= '0;
      key_error_q <= 1'b0;
    end else begin
      keypad_q    <= '0;
      key_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_s_q != '0) begin
            if ($onehot(key_s_q)) begin
              code_q  <= key_s_q;
              kcnt_q  <= CNT_ONE;
              state_q <= QUAL;
            end else begin
              key_error_q <= 1'b1;
              kcnt_q      <= '0;
              state_q     <= RELEASE;
            end
          end
        end
        QUAL: begin
          if (key_s_q == code_q) begin
            if (kcnt_q == DB_LAST) begin
              keypad_q <= code_q;
              kcnt_q   <= '0;
              state_q  <= RELEASE;
            end else begin
              kcnt_q <= kcnt_q + CNT_ONE;
            end
          end else if (key_s_q == '0) begin
            kcnt_q  <= '0;
            state_q <= IDLE;
          end else begin
            key_error_q <= 1'b1;
            kcnt_q      <= '0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_s_q != '0) begin
            kcnt_q <= '0;
          end else if (kcnt_q == DB_LAST) begin
            kcnt_q  <= '0;
            state_q <= IDLE;
          end else begin
            kcnt_q <= kcnt_q + CNT_ONE;
          end
        end
        default: begin
          kcnt_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign keypad      = keypad_q;
  assign key_error   = key_error_q;
  assign startn      = btn_q[0];
  assign stopn       = btn_q[1];
  assign clearn      = btn_q[2];
  assign door_closed = btn_q[3];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: reset, key qualification, bounce,
// multi-key error, button debounce and reset during a press.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_raw;
  logic       startn_raw, stopn_raw, clearn_raw, door_raw;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed, key_error;

  int tests_run    = 0;
  int tests_failed = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .startn_raw (startn_raw),
    .stopn_raw  (stopn_raw),
    .clearn_raw (clearn_raw),
    .door_raw   (door_raw),
    .keypad     (keypad),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .key_error  (key_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_keys();
    key_raw = '0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (keypad !== 10'd0 || key_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_key: keypad=%b key_error=%b, want 0/0", keypad, key_error);
    end
    tests_run++;
    if ({startn, stopn, clearn, door_closed} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL reset_btn: {start,stop,clear,door}=%b, want 1110",
               {startn, stopn, clearn, door_closed});
    end
    rst = 1'b0;
    door_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        tests_run++;
        if (door_closed !== 1'b0) begin
          tests_failed++;
          $display("FAIL door_early: door_closed=%b at edge 4 after sample, want 0", door_closed);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (door_closed !== 1'b1) begin
          tests_failed++;
          $display("FAIL door_latency: door_closed=%b at edge 5 after sample, want 1", door_closed);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int first = 0;
    logic [9:0] val = '0;
    key_raw = 10'b0000000010;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (keypad !== 10'd0) begin
        pulses++;
        if (first == 0) begin
          first = k;
          val = keypad;
        end
      end
    end
    tests_run++;
    if (pulses != 1 || first != 6 || val !== 10'b0000000010) begin
      tests_failed++;
      $display("FAIL clean_press: pulses=%0d step=%0d code=%b, want 1/6/0000000010",
               pulses, first, val);
    end
    release_keys();
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int first = 0;
    logic [9:0] val = '0;
    for (int i = 0; i < 6; i++) begin
      key_raw = (i % 2 == 0) ? 10'b1000000000 : 10'b0000000000;
      step();
      if (keypad !== 10'd0) pulses++;
    end
    key_raw = 10'b1000000000;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (keypad !== 10'd0) begin
        pulses++;
        if (first == 0) begin
          first = k;
          val = keypad;
        end
      end
    end
    tests_run++;
    if (pulses != 1 || first != 6 || val !== 10'b1000000000) begin
      tests_failed++;
      $display("FAIL bounce: pulses=%0d step=%0d code=%b, want 1/6/1000000000",
               pulses, first, val);
    end
    release_keys();
  endtask

  task automatic test_multi_key();
    int errs = 0;
    int err_at = 0;
    int pulses = 0;
    int first = 0;
    logic [9:0] val = '0;
    key_raw = 10'b0000000011;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (key_error === 1'b1) begin
        errs++;
        if (err_at == 0) err_at = k;
      end
      if (keypad !== 10'd0) pulses++;
    end
    tests_run++;
    if (errs != 1 || err_at != 3) begin
      tests_failed++;
      $display("FAIL multi_err: key_error pulses=%0d step=%0d, want 1/3", errs, err_at);
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL multi_keypad: keypad pulses=%0d, want 0", pulses);
    end
    release_keys();
    pulses = 0;
    key_raw = 10'b0000000100;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (keypad !== 10'd0) begin
        pulses++;
        if (first == 0) begin
          first = k;
          val = keypad;
        end
      end
      if (key_error !== 1'b0) errs++;
    end
    tests_run++;
    if (pulses != 1 || first != 6 || val !== 10'b0000000100 || errs != 1) begin
      tests_failed++;
      $display("FAIL after_multi: pulses=%0d step=%0d code=%b errs=%0d, want 1/6/0000000100/1",
               pulses, first, val, errs);
    end
    release_keys();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    key_raw = 10'b0000001000;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (keypad !== 10'd0) pulses++;
    end
    key_raw = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (keypad !== 10'd0) pulses++;
    end
    key_raw = 10'b0000001000;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (keypad !== 10'd0) pulses++;
    end
    tests_run++;
    if (pulses != 2) begin
      tests_failed++;
      $display("FAIL back_to_back: pulses=%0d, want 2", pulses);
    end
    release_keys();
  endtask

  task automatic test_buttons();
    int bad = 0;
    startn_raw = 1'b0;
    repeat (3) step();
    startn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (startn !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL start_glitch: startn low on %0d cycles, want 0", bad);
    end
    startn_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5) begin
        tests_run++;
        if (startn !== 1'b1) begin
          tests_failed++;
          $display("FAIL start_early: startn=%b at step 5, want 1", startn);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (startn !== 1'b0) begin
          tests_failed++;
          $display("FAIL start_hold: startn=%b at step 6, want 0", startn);
        end
      end
    end
    startn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        tests_run++;
        if (startn !== 1'b0) begin
          tests_failed++;
          $display("FAIL start_rel_early: startn=%b at step 5, want 0", startn);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (startn !== 1'b1) begin
          tests_failed++;
          $display("FAIL start_release: startn=%b at step 6, want 1", startn);
        end
      end
    end
    stopn_raw  = 1'b0;
    clearn_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        tests_run++;
        if ({stopn, clearn} !== 2'b11) begin
          tests_failed++;
          $display("FAIL stop_clear_early: {stopn,clearn}=%b at step 5, want 11", {stopn, clearn});
        end
      end
    end
    tests_run++;
    if ({startn, stopn, clearn, door_closed} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL stop_clear_hold: {start,stop,clear,door}=%b, want 1001",
               {startn, stopn, clearn, door_closed});
    end
    stopn_raw  = 1'b1;
    clearn_raw = 1'b1;
    repeat (8) step();
    tests_run++;
    if ({stopn, clearn} !== 2'b11) begin
      tests_failed++;
      $display("FAIL stop_clear_release: {stopn,clearn}=%b, want 11", {stopn, clearn});
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    int first = 0;
    logic [9:0] val = '0;
    key_raw = 10'b0000100000;
    repeat (3) begin
      step();
      if (keypad !== 10'd0) pulses++;
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      if (keypad !== 10'd0 || key_error !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0 || door_closed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: pulses=%0d door_closed=%b, want 0/0", pulses, door_closed);
    end
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (keypad !== 10'd0) begin
        pulses++;
        if (first == 0) begin
          first = k;
          val = keypad;
        end
      end
    end
    tests_run++;
    if (pulses != 1 || first != 6 || val !== 10'b0000100000) begin
      tests_failed++;
      $display("FAIL reset_repress: pulses=%0d step=%0d code=%b, want 1/6/0000100000",
               pulses, first, val);
    end
    release_keys();
  endtask

  initial begin
    rst        = 1'b1;
    key_raw    = '0;
    startn_raw = 1'b1;
    stopn_raw  = 1'b1;
    clearn_raw = 1'b1;
    door_raw   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_buttons();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
